// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares a single W-bit adder among NREQ requesters.
// One transaction in flight: grant -> drive adder operands -> capture sum -> respond.
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_sum,
    output logic                rsp_valid,
    output logic [W-1:0]        rsp_sum,
    output logic [IDW-1:0]      rsp_id,
    input  logic                rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDW-1:0]        rr_ptr_r;
    logic [IDW-1:0]        id_r;
    logic [IDW-1:0]        winner_s;
    logic [IDW-1:0]        ptr_nxt_s;
    logic [2*NREQ-1:0]     dbl_s;
    logic [NREQ-1:0]       rot_s;
    logic [IDW:0]          cand_s;
    logic                  found_s;
    logic                  any_s;
    logic                  grant_s;
    logic [W-1:0]          add_a_r;
    logic [W-1:0]          add_b_r;
    logic                  rsp_valid_r;
    logic [W-1:0]          rsp_sum_r;
    logic [IDW-1:0]        rsp_id_r;

    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_id    = rsp_id_r;

    // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the first set bit.
    always_comb begin
        dbl_s    = {req_valid, req_valid} >> rr_ptr_r;
        rot_s    = dbl_s[NREQ-1:0];
        winner_s = rr_ptr_r;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            if (cand_s >= (IDW+1)'(NREQ)) begin
                cand_s = cand_s - (IDW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && rot_s[k]) begin
                found_s  = 1'b1;
                winner_s = cand_s[IDW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
        if (winner_s == IDW'(NREQ-1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = winner_s + IDW'(1);
        end
    end

    // Grant is possible in IDLE, or in RESP on the same cycle the response is consumed.
    always_comb begin
        any_s   = |req_valid;
        grant_s = any_s && rst_n &&
                  ((state_r == IDLE) || ((state_r == RESP) && rsp_ready));
        if (grant_s) begin
            req_ready = NREQ'(1) << winner_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) state_nxt_s = ADD;
                else         state_nxt_s = IDLE;
            end
            ADD: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (!rsp_ready)   state_nxt_s = RESP;
                else if (grant_s) state_nxt_s = ADD;
                else              state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Operand, pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            id_r        <= '0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_sum_r   <= '0;
            rsp_id_r    <= '0;
        end else begin
            if (grant_s) begin
                add_a_r  <= req_a[int'(winner_s)*W +: W];
                add_b_r  <= req_b[int'(winner_s)*W +: W];
                id_r     <= winner_s;
                rr_ptr_r <= ptr_nxt_s;
            end
            // The adder has no carry-out, so the sum is taken as-is (modulo 2^W).
            if (state_r == ADD) begin
                rsp_sum_r   <= add_sum;
                rsp_id_r    <= id_r;
                rsp_valid_r <= 1'b1;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: vector table for single transactions,
// hand-written sequences for round-robin, backpressure, reset and pointer skip.
module tb_adder_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        rsp_valid;
    logic [3:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ready;

    logic [3:0]  opa [4];
    logic [3:0]  opb [4];

    typedef struct {
        logic [3:0] sum;
        logic [1:0] id;
    } exp_t;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   n_pass;
    int   n_total;
    exp_t e_bp;

    adder_share_arb #(.NREQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    // The shared 4-bit adder: no carry-out.
    assign add_sum = add_a + add_b;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*4 +: 4] = opa[i];
            req_b[i*4 +: 4] = opb[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_op(input int id);
        exp_t e;
        e.sum = 4'(opa[id] + opb[id]);
        e.id  = 2'(id);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: each accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got id %0d sum %0d expected no response", rsp_id, rsp_sum);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{idx: 0, a: 4'd3,  b: 4'd5,  sum: 4'd8};
        vecs[1] = '{idx: 2, a: 4'd9,  b: 4'd8,  sum: 4'd1};
        vecs[2] = '{idx: 2, a: 4'd15, b: 4'd15, sum: 4'd14};
        vecs[3] = '{idx: 1, a: 4'd7,  b: 4'd6,  sum: 4'd13};
        vecs[4] = '{idx: 3, a: 4'd0,  b: 4'd0,  sum: 4'd0};
        vecs[5] = '{idx: 3, a: 4'd15, b: 4'd1,  sum: 4'd0};
        for (int i = 0; i < 4; i++) begin
            opa[i] = 4'd0;
            opb[i] = 4'd0;
        end

        // Reset: req_ready forced low even with requests pending.
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        repeat (2) @(posedge clk);
        req_valid = 4'h0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-requester transactions with exact latency checks.
        for (int v = 0; v < 6; v++) begin
            opa[vecs[v].idx] = vecs[v].a;
            opb[vecs[v].idx] = vecs[v].b;
            req_valid = 4'(1 << vecs[v].idx);
            rsp_ready = 1'b1;
            #1;
            chk("vec_grant", 32'(req_ready), 32'(1 << vecs[v].idx));
            sb_q.push_back('{sum: vecs[v].sum, id: 2'(vecs[v].idx)});
            @(posedge clk); #1;
            req_valid = 4'h0;
            chk("vec_add_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("vec_add_a", 32'(add_a), 32'(vecs[v].a));
            chk("vec_add_b", 32'(add_b), 32'(vecs[v].b));
            chk("vec_add_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
            chk("vec_rsp_drop", 32'(rsp_valid), 32'd0);
        end
        chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);

        // Round-robin fairness from a fresh reset: grants 0,1,2,3,0 every 2 cycles.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 4'(3*i + 1);
            opb[i] = 4'(5*i + 2);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            push_op(g % 4);
            @(posedge clk); #1;
            chk("rr_add_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
        end
        #1;

        // Backpressure: in RESP with requester 0's result, requests pending.
        rsp_ready = 1'b0;
        e_bp.sum  = 4'(opa[0] + opb[0]);
        e_bp.id   = 2'd0;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum", 32'(rsp_sum), 32'(e_bp.sum));
            chk("bp_id", 32'(rsp_id), 32'(e_bp.id));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_b2b_grant", 32'(req_ready), 32'b0010);
        push_op(1);
        @(posedge clk); #1;
        req_valid = 4'h0;
        drain();

        // Reset in ADD: transaction dropped, pointer back to 0.
        opa[1] = 4'd4;
        opb[1] = 4'd9;
        opa[3] = 4'd2;
        opb[3] = 4'd2;
        req_valid = 4'b0010;
        #1;
        chk("rm_grant", 32'(req_ready), 32'b0010);
        push_op(1);
        @(posedge clk); #1;
        req_valid = 4'h0;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rm_add_a", 32'(add_a), 32'd0);
        chk("rm_add_b", 32'(add_b), 32'd0);
        chk("rm_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rm_no_stale", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rm_no_stale2", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1010;
        #1;
        chk("rm_first_grant", 32'(req_ready), 32'b0010);
        push_op(1);
        @(posedge clk); #1;
        req_valid = 4'h0;
        drain();

        // Pointer skip: grant 0 (pointer -> 1), then only req 0 again, then 0 and 1.
        opa[0] = 4'd6;
        opb[0] = 4'd7;
        req_valid = 4'b0001;
        #1;
        chk("ps_grant_a", 32'(req_ready), 32'b0001);
        push_op(0);
        @(posedge clk); #1;
        req_valid = 4'h0;
        drain();
        opa[0] = 4'd10;
        opb[0] = 4'd11;
        req_valid = 4'b0001;
        #1;
        chk("ps_grant_skip", 32'(req_ready), 32'b0001);
        push_op(0);
        @(posedge clk); #1;
        req_valid = 4'h0;
        drain();
        req_valid = 4'b0011;
        #1;
        chk("ps_ptr_is_1", 32'(req_ready), 32'b0010);
        push_op(1);
        @(posedge clk); #1;
        req_valid = 4'h0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
